// File: rtl/seq_match_ctrl_if.sv
// Bus bundle for seq_match_ctrl: configuration handshake, control strobes,
// serial input and status outputs. The host side uses the master modport,
// the controller uses the slave modport.
interface seq_match_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
);
  // Configuration handshake: a config word transfers on any clock edge where
  // cfg_valid and cfg_ready are both high. cfg_ready is low only while ARMED;
  // the host may hold cfg_valid high across not-ready cycles and nothing is
  // latched until cfg_ready returns.
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [MAX_LEN-1:0]   cfg_pattern;
  logic [LEN_W-1:0]     cfg_len;
  logic [CNT_W-1:0]     cfg_target;
  logic [TO_W-1:0]      cfg_timeout;
  logic                 start;
  logic                 abort;
  logic                 din_valid;
  logic                 din;
  logic                 busy;
  logic                 match_pulse;
  logic [CNT_W-1:0]     match_count;
  logic                 done;
  logic                 timed_out;
  logic [1:0]           dbg_state;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_timeout,
    output start, abort, din_valid, din,
    input  cfg_ready, busy, match_pulse, match_count, done, timed_out, dbg_state
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_timeout,
    input  start, abort, din_valid, din,
    output cfg_ready, busy, match_pulse, match_count, done, timed_out, dbg_state
  );
endinterface

// File: rtl/seq_match_ctrl.sv
// Run-time configurable serial pattern-match controller. Latches a pattern
// configuration, arms on start, counts overlapping matches in the qualified
// serial stream and finishes on a target count (done) or a cycle budget
// (timed_out). All outputs come straight from registers.
module seq_match_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input logic               clk,
  input logic               rst,
  seq_match_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   pat_q, pat_d, hist_q, hist_d;
  logic [LEN_W-1:0]     len_q, len_d, fill_q, fill_d;
  logic [CNT_W-1:0]     tgt_q, tgt_d, cnt_q, cnt_d;
  logic [TO_W-1:0]      tmo_q, tmo_d, tcnt_q, tcnt_d;
  logic                 busy_q, busy_d, pulse_q, pulse_d;
  logic                 done_q, done_d, tout_q, tout_d;

  logic [LEN_W-1:0]     len_in, fill_nx;
  logic [MAX_LEN-1:0]   mask, shifted;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 cfg_ready, cfg_fire, hit;

  assign cfg_ready = (state_q != ARMED);
  assign cfg_fire  = bus.cfg_valid && cfg_ready;

  // Length 0 behaves as 1; anything beyond the history width clamps to it.
  always_comb begin
    len_in = bus.cfg_len;
    if (bus.cfg_len == '0) len_in = LEN_W'(1);
    else if (bus.cfg_len > LEN_W'(MAX_LEN)) len_in = LEN_W'(MAX_LEN);
  end

  // Compare window: the low len bits of history and pattern.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len_q);
  end

  // History with the current bit included; the fill count saturates at len
  // so a match needs at least len bits received since arming.
  assign shifted = {hist_q[MAX_LEN-2:0], bus.din};
  assign fill_nx = (fill_q < len_q) ? fill_q + 1'b1 : fill_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign hit     = (state_q == ARMED) && bus.din_valid && (fill_nx >= len_q) &&
                   (((shifted ^ pat_q) & mask) == '0);

  // Next-state and next-output logic; abort overrides everything except
  // the config latch, and a completing match beats an expiring budget.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    tgt_d   = tgt_q;
    tmo_d   = tmo_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    tcnt_d  = tcnt_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    pulse_d = 1'b0;
    done_d  = done_q;
    tout_d  = tout_q;
    if (cfg_fire) begin
      pat_d = bus.cfg_pattern;
      len_d = len_in;
      tgt_d = bus.cfg_target;
      tmo_d = bus.cfg_timeout;
    end
    if (bus.abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      tout_d  = 1'b0;
      cnt_d   = '0;
      hist_d  = '0;
      fill_d  = '0;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE, DONE, TIMEOUT: begin
          if (bus.start) begin
            state_d = ARMED;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            tout_d  = 1'b0;
            cnt_d   = '0;
            hist_d  = '0;
            fill_d  = '0;
            tcnt_d  = '0;
          end
        end
        ARMED: begin
          tcnt_d = tcnt_q + 1'b1;
          if (bus.din_valid) begin
            hist_d = shifted;
            fill_d = fill_nx;
          end
          if (hit) begin
            pulse_d = 1'b1;
            cnt_d   = cnt_inc;
          end
          if (hit && (tgt_q != '0) && (cnt_inc == tgt_q)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if ((tmo_q != '0) && (tcnt_q == tmo_q)) begin
            state_d = TIMEOUT;
            busy_d  = 1'b0;
            tout_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Config, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      tgt_q   <= CNT_W'(1);
      tmo_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      tcnt_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      tgt_q   <= tgt_d;
      tmo_q   <= tmo_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      tcnt_q  <= tcnt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.cfg_ready   = cfg_ready;
  assign bus.busy        = busy_q;
  assign bus.match_pulse = pulse_q;
  assign bus.match_count = cnt_q;
  assign bus.done        = done_q;
  assign bus.timed_out   = tout_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl: one task per scenario, inline checks,
// a pass/total tally and a single summary line.
module tb_seq_match_ctrl;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  seq_match_ctrl_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .TO_W(16)) bus ();

  seq_match_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .TO_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge, and
  // outputs are sampled at that same point, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l,
                           input logic [7:0] t, input logic [15:0] to);
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_target  = t;
    bus.cfg_timeout = to;
    bus.cfg_valid   = 1'b1;
    tick();
    bus.cfg_valid   = 1'b0;
  endtask

  task automatic arm();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic b, input logic v);
    bus.din       = b;
    bus.din_valid = v;
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", bus.busy); else passed++;
    total++; if (bus.match_pulse !== 1'b0) $display("FAIL rst_pulse got %0b exp 0", bus.match_pulse); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL rst_done got %0b exp 0", bus.done); else passed++;
    total++; if (bus.timed_out !== 1'b0) $display("FAIL rst_tout got %0b exp 0", bus.timed_out); else passed++;
    total++; if (bus.match_count !== 8'd0) $display("FAIL rst_count got %0d exp 0", bus.match_count); else passed++;
    total++; if (bus.cfg_ready !== 1'b1) $display("FAIL rst_cfg_ready got %0b exp 1", bus.cfg_ready); else passed++;
    total++; if (bus.dbg_state !== 2'd0) $display("FAIL rst_state got %0d exp 0", bus.dbg_state); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic_done();
    logic b_a [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic p_a [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    configure(8'h05, 4'd4, 8'd2, 16'd0);
    arm();
    total++; if (bus.busy !== 1'b1) $display("FAIL basic_busy_rise got %0b exp 1", bus.busy); else passed++;
    total++; if (bus.cfg_ready !== 1'b0) $display("FAIL basic_cfg_ready got %0b exp 0", bus.cfg_ready); else passed++;
    for (int i = 0; i < 6; i++) begin
      send(b_a[i], 1'b1);
      total++; if (bus.match_pulse !== p_a[i]) $display("FAIL basic_pulse bit%0d got %0b exp %0b", i, bus.match_pulse, p_a[i]); else passed++;
    end
    total++; if (bus.match_count !== 8'd2) $display("FAIL basic_count got %0d exp 2", bus.match_count); else passed++;
    total++; if (bus.done !== 1'b1) $display("FAIL basic_done got %0b exp 1", bus.done); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_fall got %0b exp 0", bus.busy); else passed++;
    tick();
    total++; if (bus.match_pulse !== 1'b0) $display("FAIL basic_pulse_clear got %0b exp 0", bus.match_pulse); else passed++;
    total++; if (bus.done !== 1'b1) $display("FAIL basic_done_hold got %0b exp 1", bus.done); else passed++;
    total++; if (bus.dbg_state !== 2'd2) $display("FAIL basic_state got %0d exp 2", bus.dbg_state); else passed++;
  endtask

  task automatic test_gaps();
    logic b_a [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic v_a [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic p_a [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    configure(8'h05, 4'd4, 8'd3, 16'd0);
    arm();
    for (int i = 0; i < 9; i++) begin
      send(b_a[i], v_a[i]);
      total++; if (bus.match_pulse !== p_a[i]) $display("FAIL gaps_pulse step%0d got %0b exp %0b", i, bus.match_pulse, p_a[i]); else passed++;
    end
    total++; if (bus.match_count !== 8'd1) $display("FAIL gaps_count got %0d exp 1", bus.match_count); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL gaps_done got %0b exp 0", bus.done); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL gaps_busy got %0b exp 1", bus.busy); else passed++;
    do_abort();
  endtask

  task automatic test_unlimited();
    logic p_a [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    configure(8'h03, 4'd2, 8'd0, 16'd0);
    arm();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b1);
      total++; if (bus.match_pulse !== p_a[i]) $display("FAIL unl_pulse bit%0d got %0b exp %0b", i, bus.match_pulse, p_a[i]); else passed++;
    end
    total++; if (bus.match_count !== 8'd4) $display("FAIL unl_count got %0d exp 4", bus.match_count); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL unl_busy got %0b exp 1", bus.busy); else passed++;
    total++; if (bus.dbg_state !== 2'd1) $display("FAIL unl_state got %0d exp 1", bus.dbg_state); else passed++;
    do_abort();
    total++; if (bus.busy !== 1'b0) $display("FAIL unl_abort_busy got %0b exp 0", bus.busy); else passed++;
    total++; if (bus.match_count !== 8'd0) $display("FAIL unl_abort_count got %0d exp 0", bus.match_count); else passed++;
  endtask

  task automatic test_timeout();
    logic b_a [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    configure(8'h05, 4'd4, 8'd1, 16'd10);
    arm();
    for (int i = 0; i < 10; i++) send(1'b0, 1'b1);
    total++; if (bus.timed_out !== 1'b0) $display("FAIL to_early got %0b exp 0", bus.timed_out); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL to_busy_early got %0b exp 1", bus.busy); else passed++;
    send(1'b0, 1'b1);
    total++; if (bus.timed_out !== 1'b1) $display("FAIL to_expire got %0b exp 1", bus.timed_out); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL to_busy got %0b exp 0", bus.busy); else passed++;
    total++; if (bus.match_count !== 8'd0) $display("FAIL to_count got %0d exp 0", bus.match_count); else passed++;
    total++; if (bus.dbg_state !== 2'd3) $display("FAIL to_state got %0d exp 3", bus.dbg_state); else passed++;
    arm();
    total++; if (bus.timed_out !== 1'b0) $display("FAIL to_rearm_clear got %0b exp 0", bus.timed_out); else passed++;
    for (int i = 0; i < 11; i++) send(b_a[i], 1'b1);
    total++; if (bus.done !== 1'b1) $display("FAIL tie_done got %0b exp 1", bus.done); else passed++;
    total++; if (bus.timed_out !== 1'b0) $display("FAIL tie_tout got %0b exp 0", bus.timed_out); else passed++;
    total++; if (bus.match_count !== 8'd1) $display("FAIL tie_count got %0d exp 1", bus.match_count); else passed++;
  endtask

  task automatic test_len_edges();
    logic p1_a [3] = '{1'b1, 1'b0, 1'b1};
    logic b2_a [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic p2_a [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    configure(8'h01, 4'd0, 8'd0, 16'd0);
    arm();
    for (int i = 0; i < 3; i++) begin
      send(p1_a[i], 1'b1);
      total++; if (bus.match_pulse !== p1_a[i]) $display("FAIL len0_pulse bit%0d got %0b exp %0b", i, bus.match_pulse, p1_a[i]); else passed++;
    end
    total++; if (bus.match_count !== 8'd2) $display("FAIL len0_count got %0d exp 2", bus.match_count); else passed++;
    do_abort();
    configure(8'hA5, 4'd15, 8'd0, 16'd0);
    arm();
    for (int i = 0; i < 8; i++) begin
      send(b2_a[i], 1'b1);
      total++; if (bus.match_pulse !== p2_a[i]) $display("FAIL clamp_pulse bit%0d got %0b exp %0b", i, bus.match_pulse, p2_a[i]); else passed++;
    end
    total++; if (bus.cfg_ready !== 1'b0) $display("FAIL armed_cfg_ready got %0b exp 0", bus.cfg_ready); else passed++;
    bus.cfg_pattern = 8'h01;
    bus.cfg_len     = 4'd1;
    bus.cfg_target  = 8'd0;
    bus.cfg_timeout = 16'd0;
    bus.cfg_valid   = 1'b1;
    tick();
    bus.cfg_valid   = 1'b0;
    do_abort();
    arm();
    send(1'b1, 1'b1);
    total++; if (bus.match_pulse !== 1'b0) $display("FAIL armed_nolatch_pulse got %0b exp 0", bus.match_pulse); else passed++;
    total++; if (bus.match_count !== 8'd0) $display("FAIL armed_nolatch_count got %0d exp 0", bus.match_count); else passed++;
    do_abort();
  endtask

  task automatic test_abort_rearm();
    logic b_a [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic p_a [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    configure(8'h05, 4'd4, 8'd1, 16'd0);
    arm();
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    do_abort();
    total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %0b exp 0", bus.busy); else passed++;
    total++; if (bus.dbg_state !== 2'd0) $display("FAIL abort_state got %0d exp 0", bus.dbg_state); else passed++;
    total++; if (bus.cfg_ready !== 1'b1) $display("FAIL abort_cfg_ready got %0b exp 1", bus.cfg_ready); else passed++;
    arm();
    send(1'b1, 1'b1);
    total++; if (bus.match_pulse !== 1'b0) $display("FAIL abort_hist_pulse got %0b exp 0", bus.match_pulse); else passed++;
    total++; if (bus.match_count !== 8'd0) $display("FAIL abort_hist_count got %0d exp 0", bus.match_count); else passed++;
    for (int i = 0; i < 4; i++) begin
      send(b_a[i], 1'b1);
      total++; if (bus.match_pulse !== p_a[i]) $display("FAIL rearm_pulse bit%0d got %0b exp %0b", i, bus.match_pulse, p_a[i]); else passed++;
    end
    total++; if (bus.done !== 1'b1) $display("FAIL rearm_done got %0b exp 1", bus.done); else passed++;
  endtask

  task automatic test_rst_in_done();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.done !== 1'b0) $display("FAIL rstd_done got %0b exp 0", bus.done); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rstd_busy got %0b exp 0", bus.busy); else passed++;
    total++; if (bus.match_count !== 8'd0) $display("FAIL rstd_count got %0d exp 0", bus.match_count); else passed++;
    total++; if (bus.cfg_ready !== 1'b1) $display("FAIL rstd_cfg_ready got %0b exp 1", bus.cfg_ready); else passed++;
    total++; if (bus.dbg_state !== 2'd0) $display("FAIL rstd_state got %0d exp 0", bus.dbg_state); else passed++;
    arm();
    send(1'b1, 1'b1);
    total++; if (bus.match_pulse !== 1'b0) $display("FAIL rstd_defcfg_one got %0b exp 0", bus.match_pulse); else passed++;
    send(1'b0, 1'b1);
    total++; if (bus.match_pulse !== 1'b1) $display("FAIL rstd_defcfg_zero got %0b exp 1", bus.match_pulse); else passed++;
    total++; if (bus.done !== 1'b1) $display("FAIL rstd_defcfg_done got %0b exp 1", bus.done); else passed++;
    total++; if (bus.match_count !== 8'd1) $display("FAIL rstd_defcfg_count got %0d exp 1", bus.match_count); else passed++;
  endtask

  // Sequencer and final report
  initial begin
    passed          = 0;
    total           = 0;
    rst             = 1'b1;
    bus.cfg_valid   = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_target  = '0;
    bus.cfg_timeout = '0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.din_valid   = 1'b0;
    bus.din         = 1'b0;
    test_reset();
    test_basic_done();
    test_gaps();
    test_unlimited();
    test_timeout();
    test_len_edges();
    test_abort_rearm();
    test_rst_in_done();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Run-time configurable serial pattern-match controller. It accepts a pattern/length/target/timeout configuration over a valid/ready handshake, arms on `start`, and scans a qualified serial bit stream for overlapping occurrences of the pattern. It counts matches and finishes with `done` when the target count is reached, or with `timed_out` when the cycle budget expires. It sits between a host/control FSM and the serial receive path, replacing fixed-pattern detectors.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits (2..15).
- `LEN_W`, 4: width of `cfg_len`.
- `CNT_W`, 8: width of the match counter and target.
- `TO_W`, 16: width of the timeout budget.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_valid` in 1: configuration word valid.
- `cfg_ready` out 1: configuration accepted when high; low only in ARMED.
- `cfg_pattern` in MAX_LEN: pattern. Bit `len-1` is the first bit received; bit 0 is the last.
- `cfg_len` in LEN_W: pattern length. 0 is treated as 1; values above MAX_LEN clamp to MAX_LEN.
- `cfg_target` in CNT_W: matches required for `done`. 0 means unlimited.
- `cfg_timeout` in TO_W: cycle budget in ARMED. 0 disables the timeout.
- `start` in 1: arm request.
- `abort` in 1: return to IDLE.
- `din_valid` in 1: `din` qualifier.
- `din` in 1: serial data bit.
- `busy` out 1: high in ARMED.
- `match_pulse` out 1: one-cycle pulse per match.
- `match_count` out CNT_W: matches since last arm.
- `done` out 1: target reached; held high in DONE.
- `timed_out` out 1: budget expired; held high in TIMEOUT.

## Operation
- States: IDLE, ARMED, DONE, TIMEOUT. Reset puts the block in IDLE.
- Reset values:
  - Outputs: `busy`, `match_pulse`, `done`, `timed_out` = 0; `match_count` = 0; `cfg_ready` = 1.
  - Config registers: pattern 0, len 1, target 1, timeout 0.
  - Internal: history 0, fill counter 0, timeout counter 0.
- Config: `cfg_valid && cfg_ready` latches all four cfg fields at the clock edge, with len clamped. This is legal in IDLE, DONE and TIMEOUT, and does not change state.
- IDLE/DONE/TIMEOUT -> ARMED on `start`. This clears `match_count`, history, the fill counter and the timeout counter, and drops `done`/`timed_out`.
- If `cfg_valid` and `start` arrive in the same cycle, the new config is used for that arm.
- ARMED:
  - Each `din_valid` cycle shifts `din` into the history LSB. The fill counter increments, saturating at len.
  - A match occurs when the fill counter (including this bit) is at least len and `history[len-1:0]` including `din` equals `pattern[len-1:0]`.
  - Overlapping matches count. History is not cleared on a match.
  - `din_valid` low means no shift and no match. `start` in ARMED is ignored.
- On a match, `match_pulse` is asserted and `match_count` increments, saturating at all-ones.
- ARMED -> DONE when a match makes the count equal a nonzero target.
- ARMED -> TIMEOUT when the timeout counter reaches `cfg_timeout` (nonzero) without DONE.
- If target is reached on the same cycle the budget expires, DONE wins.
- `abort` in any state -> IDLE. It clears the outputs and keeps the config. `abort` has priority over `start`, match and timeout.

## Timing
- All outputs are registered.
- Config latch to effect: the next `start` uses the new values. `cfg_ready` falls the cycle after `start` is sampled.
- `busy` rises 1 cycle after `start` is sampled.
- `match_pulse` and the `match_count` update appear 1 cycle after the edge that sampled the completing `din`.
- `done` rises together with the final `match_pulse`.
- Timeout counter increments every ARMED cycle, starting from 0 on the first ARMED cycle. `timed_out` rises 1 cycle after the counter equals `cfg_timeout`, i.e. `cfg_timeout`+1 cycles after `busy` rises.
- `rst` mid-operation returns to the reset values on the next edge, including the config registers.
- `abort` clears `busy`/`done`/`timed_out` on the next edge.

## Test plan
- Config 0101, len 4, target 2, timeout 0; start; stream 0,1,0,1,0,1 all valid -> `match_pulse` after bits 4 and 6, `match_count`=2, `done`=1 with the second pulse, `busy`=0.
- Same config, target 3; stream 0,1,1,0,1,0,1 with `din_valid` low on two interleaved cycles -> a single match after the last bit, `match_count`=1, no `done`. Gaps must not break the sequence.
- Config 11, len 2, target 0; stream of five 1s -> 4 pulses, `match_count`=4, remains ARMED.
- Config 0101, target 1, timeout 10; stream all 0s -> `timed_out`=1 at cycle 11 after `busy` rises, `match_count`=0. Completing the match on the expiry cycle gives `done`=1, `timed_out`=0.
- `cfg_len`=0, pattern bit0=1 -> behaves as len 1: every valid 1 matches. `cfg_len`=15 with MAX_LEN=8 -> clamps to 8. `cfg_valid` while ARMED -> `cfg_ready`=0 and no latch.
- `abort` mid-ARMED after 3 matched bits, then `start` and the final bit only -> no match (history cleared). `rst` in DONE -> all outputs 0, config back to defaults.
